// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size encodings, FSM states
// and small decode helpers used by the control stage.
package lsu_pkg;

  localparam int unsigned LSU_XLEN = 64;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_RESP = 2'd3
  } lsu_state_e;

  // Byte-enable pattern for an access of the given size at offset 0.
  function automatic logic [7:0] size_to_mask(input lsu_size_e size);
    logic [7:0] m;
    m = 8'hFF;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      SZ_D:    m = 8'hFF;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // An access is misaligned when any address bit below its natural size is set.
  function automatic logic is_misaligned(input logic [2:0] offset, input lsu_size_e size);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = offset[0];
      SZ_W:    mis = |offset[1:0];
      SZ_D:    mis = |offset[2:0];
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/MuxKeyWithDefault.sv
// Generic key/value lookup mux: the lut holds NR_KEY {key, data} pairs and
// the output is the data whose key matches, or default_out when none does.
module MuxKeyWithDefault #(
  parameter int unsigned NR_KEY   = 2,
  parameter int unsigned KEY_LEN  = 1,
  parameter int unsigned DATA_LEN = 1
) (
  output logic [DATA_LEN-1:0]                  out,
  input  logic [KEY_LEN-1:0]                   key,
  input  logic [DATA_LEN-1:0]                  default_out,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut
);

  localparam int unsigned PAIR_LEN = KEY_LEN + DATA_LEN;

  // Scan every pair; keys are expected to be unique.
  always_comb begin
    out = default_out;
    for (int unsigned i = 0; i < NR_KEY; i++) begin
      if (lut[i*PAIR_LEN+DATA_LEN +: KEY_LEN] == key) begin
        out = lut[i*PAIR_LEN +: DATA_LEN];
      end
    end
  end

endmodule

// File: rtl/lsu_load_align.sv
// Combinational load extractor: selects the addressed bytes out of a bus
// doubleword, truncates to the access size and sign/zero-extends.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      offset,
  input  lsu_size_e       size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] data
);

  localparam int unsigned PAIR_LEN = 3 + XLEN;

  logic [8*PAIR_LEN-1:0] shift_lut;
  logic [XLEN-1:0]       shifted;
  logic                  sext;

  // One table entry per byte offset: the doubleword pre-shifted right by it.
  for (genvar g = 0; g < 8; g++) begin : g_lut
    assign shift_lut[g*PAIR_LEN +: PAIR_LEN] = {3'(g), rdata >> (8*g)};
  end

  MuxKeyWithDefault #(
    .NR_KEY   (8),
    .KEY_LEN  (3),
    .DATA_LEN (XLEN)
  ) u_offset_mux (
    .out         (shifted),
    .key         (offset),
    .default_out ('0),
    .lut         (shift_lut)
  );

  // Truncate to the access width and fill the upper bits.
  always_comb begin
    sext = ~is_unsigned;
    data = shifted;
    case (size)
      SZ_B:    data = {{(XLEN-8){sext & shifted[7]}},   shifted[7:0]};
      SZ_H:    data = {{(XLEN-16){sext & shifted[15]}}, shifted[15:0]};
      SZ_W:    data = {{(XLEN-32){sext & shifted[31]}}, shifted[31:0]};
      SZ_D:    data = shifted;
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit control stage: accepts one memory operation from EXU,
// issues a single aligned doubleword bus request, and returns the aligned,
// extended load result (or store/error/misalign status) to WBU.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  parameter int unsigned AW   = 32,
  parameter int unsigned RW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic            in_wen,
  input  logic [1:0]      in_size,
  input  logic            in_unsigned,
  input  logic [RW-1:0]   in_rd,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_req_addr,
  output logic            mem_req_wen,
  output logic [XLEN-1:0] mem_req_wdata,
  output logic [7:0]      mem_req_wmask,
  input  logic            mem_rsp_valid,
  output logic            mem_rsp_ready,
  input  logic [XLEN-1:0] mem_rsp_rdata,
  input  logic            mem_rsp_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RW-1:0]   out_rd,
  output logic [XLEN-1:0] out_data,
  output logic            out_rf_wen,
  output logic            out_misalign,
  output logic            out_bus_err
);

  lsu_state_e state, next_state;

  logic [AW-1:0]   addr_q;
  logic [XLEN-1:0] wdata_q;
  logic            wen_q;
  lsu_size_e       size_q;
  logic            uns_q;
  logic [RW-1:0]   rd_q;

  logic [XLEN-1:0] out_data_q;
  logic            out_rf_wen_q;
  logic            out_misalign_q;
  logic            out_bus_err_q;

  logic            in_mis;
  logic            accept;
  logic            rsp_take;
  logic [XLEN-1:0] load_data;

  // Misalignment is judged on the incoming operation so IDLE can skip the bus.
  always_comb begin
    in_mis   = is_misaligned(in_addr[2:0], lsu_size_e'(in_size));
    accept   = (state == LSU_IDLE) && in_valid;
    rsp_take = (state == LSU_WAIT) && mem_rsp_valid;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LSU_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs; responses are only taken in WAIT.
  always_comb begin
    next_state    = state;
    in_ready      = 1'b0;
    mem_req_valid = 1'b0;
    mem_rsp_ready = 1'b0;
    out_valid     = 1'b0;
    case (state)
      LSU_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          next_state = in_mis ? LSU_RESP : LSU_REQ;
        end
      end
      LSU_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          next_state = LSU_WAIT;
        end
      end
      LSU_WAIT: begin
        mem_rsp_ready = 1'b1;
        if (mem_rsp_valid) begin
          next_state = LSU_RESP;
        end
      end
      LSU_RESP: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = LSU_IDLE;
        end
      end
      default: next_state = LSU_IDLE;
    endcase
  end

  // Operation capture on acceptance and result capture on entry to RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q         <= '0;
      wdata_q        <= '0;
      wen_q          <= 1'b0;
      size_q         <= SZ_B;
      uns_q          <= 1'b0;
      rd_q           <= '0;
      out_data_q     <= '0;
      out_rf_wen_q   <= 1'b0;
      out_misalign_q <= 1'b0;
      out_bus_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= in_addr;
        wdata_q <= in_wdata;
        wen_q   <= in_wen;
        size_q  <= lsu_size_e'(in_size);
        uns_q   <= in_unsigned;
        rd_q    <= in_rd;
        if (in_mis) begin
          out_data_q     <= '0;
          out_rf_wen_q   <= 1'b0;
          out_misalign_q <= 1'b1;
          out_bus_err_q  <= 1'b0;
        end
      end
      if (rsp_take) begin
        out_data_q     <= (mem_rsp_err || wen_q) ? '0 : load_data;
        out_rf_wen_q   <= !wen_q && !mem_rsp_err;
        out_misalign_q <= 1'b0;
        out_bus_err_q  <= mem_rsp_err;
      end
    end
  end

  lsu_load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .rdata       (mem_rsp_rdata),
    .offset      (addr_q[2:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (load_data)
  );

  // Bus request fields come straight from the captured operation.
  always_comb begin
    mem_req_addr  = {addr_q[AW-1:3], 3'b000};
    mem_req_wen   = wen_q;
    mem_req_wdata = wdata_q << {addr_q[2:0], 3'b000};
    mem_req_wmask = wen_q ? (size_to_mask(size_q) << addr_q[2:0]) : 8'h00;
    out_rd        = rd_q;
    out_data      = out_data_q;
    out_rf_wen    = out_rf_wen_q;
    out_misalign  = out_misalign_q;
    out_bus_err   = out_bus_err_q;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases plus randomized operations
// compared against an arithmetic reference model of the LSU rules.
module tb_lsu_ctrl;

  localparam int unsigned XLEN = 64;
  localparam int unsigned AW   = 32;
  localparam int unsigned RW   = 5;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   in_addr;
  logic [XLEN-1:0] in_wdata;
  logic            in_wen;
  logic [1:0]      in_size;
  logic            in_unsigned;
  logic [RW-1:0]   in_rd;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [AW-1:0]   mem_req_addr;
  logic            mem_req_wen;
  logic [XLEN-1:0] mem_req_wdata;
  logic [7:0]      mem_req_wmask;
  logic            mem_rsp_valid;
  logic            mem_rsp_ready;
  logic [XLEN-1:0] mem_rsp_rdata;
  logic            mem_rsp_err;
  logic            out_valid;
  logic            out_ready;
  logic [RW-1:0]   out_rd;
  logic [XLEN-1:0] out_data;
  logic            out_rf_wen;
  logic            out_misalign;
  logic            out_bus_err;

  int unsigned n_vec;
  int unsigned n_bad;

  lsu_ctrl #(
    .XLEN (XLEN),
    .AW   (AW),
    .RW   (RW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_addr       (in_addr),
    .in_wdata      (in_wdata),
    .in_wen        (in_wen),
    .in_size       (in_size),
    .in_unsigned   (in_unsigned),
    .in_rd         (in_rd),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wen   (mem_req_wen),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wmask (mem_req_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_ready (mem_rsp_ready),
    .mem_rsp_rdata (mem_rsp_rdata),
    .mem_rsp_err   (mem_rsp_err),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_rd        (out_rd),
    .out_data      (out_data),
    .out_rf_wen    (out_rf_wen),
    .out_misalign  (out_misalign),
    .out_bus_err   (out_bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference load result: take the addressed bytes, then extend.
  function automatic logic [63:0] ref_load(input logic [63:0] rdata, input int unsigned off,
                                           input int unsigned size, input bit uns);
    int unsigned nbits;
    logic [63:0] v;
    logic [63:0] m;
    nbits = 8 << size;
    v = rdata >> (8 * off);
    if (nbits == 64) return v;
    m = (64'd1 << nbits) - 64'd1;
    v = v & m;
    if (!uns && v[nbits-1]) v = v | ~m;
    return v;
  endfunction

  task automatic run_op(input logic [31:0] addr, input logic [63:0] wdata, input bit wen,
                        input logic [1:0] size, input bit uns, input logic [4:0] rd,
                        input logic [63:0] rdata, input bit err,
                        input int unsigned dq, input int unsigned dr, input int unsigned dout,
                        input bit junk,
                        output logic [63:0] o_data, output logic [31:0] o_raddr,
                        output logic [7:0] o_wmask, output logic [63:0] o_wdata);
    int unsigned bytes, off, cyc;
    bit          mis, e_rf, e_err;
    logic [63:0] e_data, e_wdata;
    logic [31:0] e_raddr;
    logic [7:0]  e_wmask;

    bytes   = 1 << size;
    off     = addr % 8;
    mis     = (addr % bytes) != 0;
    e_raddr = addr - 32'(off);
    e_wmask = wen ? 8'(((1 << bytes) - 1) << off) : 8'h00;
    e_wdata = wdata << (8 * off);
    if (mis) begin
      e_data = '0; e_rf = 0; e_err = 0;
    end else if (err) begin
      e_data = '0; e_rf = 0; e_err = 1;
    end else if (wen) begin
      e_data = '0; e_rf = 0; e_err = 0;
    end else begin
      e_data = ref_load(rdata, off, size, uns); e_rf = 1; e_err = 0;
    end
    o_data = '0; o_raddr = '0; o_wmask = '0; o_wdata = '0;

    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1; in_addr = addr; in_wdata = wdata; in_wen = wen;
    in_size = size; in_unsigned = uns; in_rd = rd;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    in_addr = $urandom; in_wdata = {$urandom, $urandom}; in_wen = 1'($urandom);
    in_size = 2'($urandom); in_unsigned = 1'($urandom); in_rd = 5'($urandom);
    cyc = 1;

    if (mis) begin
      chk("mis_no_req", mem_req_valid, 0);
    end else begin
      for (int unsigned i = 0; i <= dq; i++) begin
        chk("req_valid", mem_req_valid, 1);
        chk("req_addr", mem_req_addr, e_raddr);
        chk("req_wen", mem_req_wen, wen);
        chk("req_wmask", mem_req_wmask, e_wmask);
        chk("req_wdata", mem_req_wdata, e_wdata);
        chk("in_ready_busy", in_ready, 0);
        chk("rsp_ready_in_req", mem_rsp_ready, 0);
        o_raddr = mem_req_addr; o_wmask = mem_req_wmask; o_wdata = mem_req_wdata;
        mem_req_ready = (i == dq);
        mem_rsp_valid = junk && (i == dq);
        mem_rsp_rdata = {$urandom, $urandom};
        mem_rsp_err   = junk;
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
      mem_req_ready = 0;
      for (int unsigned i = 0; i <= dr; i++) begin
        chk("rsp_ready_wait", mem_rsp_ready, 1);
        chk("req_valid_wait", mem_req_valid, 0);
        chk("out_valid_wait", out_valid, 0);
        mem_rsp_valid = (i == dr);
        mem_rsp_rdata = (i == dr) ? rdata : {$urandom, $urandom};
        mem_rsp_err   = (i == dr) ? err : 1'($urandom);
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
      mem_rsp_valid = 0;
      mem_rsp_err   = 0;
    end

    chk("latency", cyc, mis ? 1 : 3 + dq + dr);
    for (int unsigned i = 0; i <= dout; i++) begin
      chk("out_valid", out_valid, 1);
      chk("out_rd", out_rd, rd);
      chk("out_data", out_data, e_data);
      chk("out_rf_wen", out_rf_wen, e_rf);
      chk("out_misalign", out_misalign, mis);
      chk("out_bus_err", out_bus_err, e_err);
      chk("in_ready_resp", in_ready, 0);
      chk("rsp_ready_resp", mem_rsp_ready, 0);
      o_data = out_data;
      out_ready = (i == dout);
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 0;
    chk("in_ready_after", in_ready, 1);
    chk("out_valid_after", out_valid, 0);
  endtask

  logic [63:0] r_data, r_wdata;
  logic [31:0] r_raddr;
  logic [7:0]  r_wmask;

  initial begin
    n_vec = 0; n_bad = 0;
    rst_n = 0; in_valid = 0; in_addr = '0; in_wdata = '0; in_wen = 0; in_size = '0;
    in_unsigned = 0; in_rd = '0; mem_req_ready = 0; mem_rsp_valid = 0;
    mem_rsp_rdata = '0; mem_rsp_err = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_rsp_ready", mem_rsp_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_req_wmask", mem_req_wmask, 0);
    chk("rst_req_addr", mem_req_addr, 0);

    // LW signed at offset 4
    run_op(32'h8000_0004, 64'h0, 0, 2'd2, 0, 5'd3, 64'hDEAD_BEEF_1234_5678, 0, 0, 0, 0, 0,
           r_data, r_raddr, r_wmask, r_wdata);
    chk("lw_data", r_data, 64'hFFFF_FFFF_DEAD_BEEF);
    // LBU / LB at the top byte
    run_op(32'h8000_0007, 64'h0, 0, 2'd0, 1, 5'd4, 64'h8000_0000_0000_0000, 0, 0, 0, 0, 0,
           r_data, r_raddr, r_wmask, r_wdata);
    chk("lbu_data", r_data, 64'h80);
    run_op(32'h8000_0007, 64'h0, 0, 2'd0, 0, 5'd5, 64'h8000_0000_0000_0000, 0, 0, 0, 0, 0,
           r_data, r_raddr, r_wmask, r_wdata);
    chk("lb_data", r_data, 64'hFFFF_FFFF_FFFF_FF80);
    // SH at offset 2
    run_op(32'h8000_0002, 64'h1234, 1, 2'd1, 0, 5'd6, 64'h0, 0, 0, 0, 0, 0,
           r_data, r_raddr, r_wmask, r_wdata);
    chk("sh_addr", r_raddr, 32'h8000_0000);
    chk("sh_wmask", r_wmask, 8'h0C);
    chk("sh_wdata", r_wdata, 64'h1234_0000);
    // Misaligned LD, then an SB that never misaligns
    run_op(32'h8000_0004, 64'h0, 0, 2'd3, 0, 5'd7, 64'h0, 0, 0, 0, 0, 0,
           r_data, r_raddr, r_wmask, r_wdata);
    chk("ld_mis_data", r_data, 0);
    run_op(32'h8000_0003, 64'hAB, 1, 2'd0, 0, 5'd8, 64'h0, 0, 0, 0, 0, 1,
           r_data, r_raddr, r_wmask, r_wdata);
    chk("sb_wmask", r_wmask, 8'h08);
    chk("sb_wdata", r_wdata, 64'hAB00_0000);
    // Back-pressure on both sides
    run_op(32'h8000_0010, 64'h0, 0, 2'd2, 1, 5'd9, 64'h1122_3344_8899_AABB, 0, 5, 2, 3, 1,
           r_data, r_raddr, r_wmask, r_wdata);
    chk("bp_data", r_data, 64'h8899_AABB);

    // Reset while waiting for the response
    @(negedge clk);
    in_valid = 1; in_addr = 32'h8000_0020; in_wen = 0; in_size = 2'd3; in_rd = 5'd10;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0; mem_req_ready = 1;
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 0;
    chk("pre_rst_wait", mem_rsp_ready, 1);
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    chk("wrst_in_ready", in_ready, 1);
    chk("wrst_out_valid", out_valid, 0);
    chk("wrst_rsp_ready", mem_rsp_ready, 0);
    chk("wrst_req_valid", mem_req_valid, 0);
    // Bus error on a load
    run_op(32'h8000_0028, 64'h0, 0, 2'd3, 0, 5'd11, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 1, 0, 0,
           r_data, r_raddr, r_wmask, r_wdata);
    chk("err_data", r_data, 0);

    // Randomized operations
    for (int n = 0; n < 200; n++) begin
      run_op(32'h8000_0000 | ($urandom & 32'h0000_0FFF), {$urandom, $urandom},
             1'($urandom), 2'($urandom), 1'($urandom), 5'($urandom),
             {$urandom, $urandom}, ($urandom % 8) == 0,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
             1'($urandom), r_data, r_raddr, r_wmask, r_wdata);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit control stage for the NPC core, sitting directly upstream of the data-selection multiplexers. It accepts one memory operation at a time from the execute stage and issues a single 8-byte-aligned bus request. It aligns the returned doubleword by byte offset and size, sign- or zero-extends it, and hands the result to writeback over a valid/ready handshake. Stores generate a shifted byte mask and shifted write data.

## Interface
- XLEN, 64, data width; fixed at 64, bus is one doubleword.
- AW, 32, address width.
- RW, 5, destination register index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  operation offered by EXU
- in_ready  out  1  LSU can accept; high only in IDLE
- in_addr  in  AW  byte address
- in_wdata  in  XLEN  store data, LSB-justified
- in_wen  in  1  1 = store, 0 = load
- in_size  in  2  0 = B, 1 = H, 2 = W, 3 = D
- in_unsigned  in  1  zero-extend the load
- in_rd  in  RW  destination register
- mem_req_valid  out  1  bus request
- mem_req_ready  in  1  bus accepts the request
- mem_req_addr  out  AW  {addr[AW-1:3], 3'b0}
- mem_req_wen  out  1  write request
- mem_req_wdata  out  XLEN  in_wdata << (8*addr[2:0])
- mem_req_wmask  out  8  size mask << addr[2:0]; 0 for loads
- mem_rsp_valid  in  1  response present
- mem_rsp_ready  out  1  high only in WAIT
- mem_rsp_rdata  in  XLEN  read doubleword
- mem_rsp_err  in  1  bus error
- out_valid  out  1  result for WBU
- out_ready  in  1  WBU accepts
- out_rd  out  RW  destination register
- out_data  out  XLEN  aligned, extended load data; 0 for stores and errors
- out_rf_wen  out  1  load with no error
- out_misalign  out  1  address not aligned to its size
- out_bus_err  out  1  mem_rsp_err was captured

## Operation
- FSM states and transitions:
  - IDLE -> REQ on in_valid, or IDLE -> RESP if the address is misaligned.
  - REQ -> WAIT on mem_req_valid && mem_req_ready.
  - WAIT -> RESP on mem_rsp_valid.
  - RESP -> IDLE on out_ready.
- On acceptance, the LSU registers addr, wdata, wen, size, unsigned and rd. Request fields are driven from these registers and hold stable while mem_req_valid is high.
- Misaligned means addr[size-1:0] != 0: B is never misaligned, H checks addr[0], W checks addr[1:0], D checks addr[2:0]. A misaligned operation issues no bus request and produces out_misalign=1, out_rf_wen=0, out_data=0.
- Load alignment:
  - Shift the doubleword right by 8*addr[2:0], truncate to 8/16/32/64 bits.
  - Sign-extend from the top bit unless unsigned. D ignores in_unsigned.
- Store width: wmask is 0x01/0x03/0x0F/0xFF before shifting.
- Bus error: out_bus_err=1, out_rf_wen=0, out_data=0. The error applies to stores as well.
- Result fields are registered on WAIT->RESP (or IDLE->RESP) and held stable until out_ready.

## Timing
- Reset (rst_n low at a clk edge):
  - State returns to IDLE and in-flight operations are dropped.
  - All valids, mem_rsp_ready, out_* and mem_req_* are 0; in_ready is 1 on the first cycle after reset.
  - The bus is reset in the same cycle, so no stale response is expected.
- Best-case load latency, counting the acceptance edge as cycle 0:
  - mem_req_valid is high in cycle 1.
  - If ready is given in cycle 1, the response can arrive in cycle 2.
  - out_valid is high in cycle 3.
- Misaligned latency: out_valid is high in cycle 1.
- A response arriving in the same cycle as the request is not accepted; mem_rsp_ready is low in REQ.
- Throughput: one operation in flight. in_ready is low from acceptance until the cycle after the RESP handshake, so there is no bypass.
- out_valid, once raised, stays high until out_ready, with all out_* fields stable.

## Structure
- Shared package lsu_pkg holds:
  - size encodings SZ_B, SZ_H, SZ_W, SZ_D;
  - the state enum LSU_IDLE, LSU_REQ, LSU_WAIT, LSU_RESP;
  - a function returning the size-to-byte-mask mapping.
- Sub-module lsu_load_align: a combinational doubleword-to-result extractor.
  - Inputs: rdata, offset[2:0], size, unsigned. Output: data.
  - Built on the team's MuxKeyWithDefault for the 8-way offset select.
- lsu_ctrl contains the FSM, registers, misalign check and store shifting.

## Test plan
- LW, addr 0x80000004, rdata 0xDEADBEEF_12345678, signed -> out_data 0xFFFFFFFF_DEADBEEF, out_rf_wen=1, out_valid in cycle 3 with immediate ready.
- LBU, addr 0x80000007, rdata 0x8000000000000000 -> out_data 0x80. The same access as LB -> 0xFFFFFFFFFFFFFF80.
- SH, addr 0x80000002, wdata 0x1234 -> mem_req_addr 0x80000000, wmask 0x0C, wdata 0x12340000, out_rf_wen=0.
- LD, addr 0x80000004 -> no mem_req_valid, out_misalign=1 in cycle 1. Then an SB at 0x80000003 -> no misalign.
- mem_req_ready held low 5 cycles, out_ready low 3 cycles -> request fields and outputs stable throughout, in_ready low until the RESP handshake.
- rst_n low while in WAIT -> next cycle IDLE, in_ready=1, out_valid=0. A mem_rsp_err=1 on a later load -> out_bus_err=1, out_data=0.
